pi_switch_ctrl: RTL and testbench

Registered control and data path for one pi-switch node of the butterfly fat tree. It samples the four incoming packet buses (left child, right child, up-left and up-right parent links) and decodes each destination into a route direction. It arbitrates the four buses onto the four outgoing links with bufferless deflection priority and drives registered output buses plus mux selects. It also keeps the up-port toggle bit and a saturating deflection counter for profiling.

---
 rtl/pi_switch_if.sv | 33 +++
 rtl/pi_switch_ctrl.sv | 158 +++++++++++++++
 tb/tb_pi_switch_ctrl.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/pi_switch_if.sv
// Packet buses, routing selects and profiling controls of one pi-switch node.
// Handshake: a bus carries a packet every cycle with its valid bit at p_sz-1; there is no ready, so every word is accepted.
interface pi_switch_if #(
  parameter int p_sz = 49
);
  logic [p_sz-1:0] l_bus_i;
  logic [p_sz-1:0] r_bus_i;
  logic [p_sz-1:0] ul_bus_i;
  logic [p_sz-1:0] ur_bus_i;
  logic [p_sz-1:0] l_bus_o;
  logic [p_sz-1:0] r_bus_o;
  logic [p_sz-1:0] ul_bus_o;
  logic [p_sz-1:0] ur_bus_o;
  logic [1:0]      sel_l;
  logic [1:0]      sel_r;
  logic [1:0]      sel_ul;
  logic [1:0]      sel_ur;
  logic            defl_clr;
  logic [15:0]     defl_cnt;
  logic            toggle;

  modport master (
    output l_bus_i, r_bus_i, ul_bus_i, ur_bus_i, defl_clr,
    input  l_bus_o, r_bus_o, ul_bus_o, ur_bus_o,
    input  sel_l, sel_r, sel_ul, sel_ur, defl_cnt, toggle
  );

  modport slave (
    input  l_bus_i, r_bus_i, ul_bus_i, ur_bus_i, defl_clr,
    output l_bus_o, r_bus_o, ul_bus_o, ur_bus_o,
    output sel_l, sel_r, sel_ul, sel_ur, defl_cnt, toggle
  );
endinterface

// File: rtl/pi_switch_ctrl.sv
// Two-stage pi-switch node: registered inputs, bufferless deflection arbitration onto four
// registered output links, up-port toggle and saturating deflection counter.
module pi_switch_ctrl #(
  parameter int p_sz    = 49,
  parameter int addr_sz = 3,
  parameter int level   = 1,
  parameter int pos     = 0
) (
  input logic        clk,
  input logic        reset_n,
  pi_switch_if.slave sw
);
  localparam logic [1:0] D_VOID  = 2'b00;
  localparam logic [1:0] D_LEFT  = 2'b01;
  localparam logic [1:0] D_RIGHT = 2'b10;
  localparam logic [1:0] D_UP    = 2'b11;
  // Slot and input indices share one numbering: L, R, U1/UL, U2/UR.
  localparam logic [1:0] S_L  = 2'd0;
  localparam logic [1:0] S_R  = 2'd1;
  localparam logic [1:0] S_U1 = 2'd2;
  localparam logic [1:0] S_U2 = 2'd3;
  localparam logic [addr_sz-1:0] pos_w = addr_sz'(pos);

  logic [3:0][p_sz-1:0] in_q;
  logic [3:0][1:0]      dir;
  logic [3:0][1:0]      tgt;
  logic [3:0][1:0]      src;
  logic [3:0][1:0]      sel_s;
  logic [3:0][p_sz-1:0] slot_pkt;
  logic [3:0]           used;
  logic                 up_busy;
  logic [2:0]           defl_n;
  logic [16:0]          cnt_sum;

  logic [p_sz-1:0] l_q, r_q, ul_q, ur_q;
  logic [1:0]      sel_l_q, sel_r_q, sel_ul_q, sel_ur_q;
  logic            toggle_q;
  logic [15:0]     cnt_q;

  function automatic logic [1:0] route(input logic [p_sz-1:0] pkt);
    logic [addr_sz-1:0] addr;
    addr = pkt[p_sz-2 -: addr_sz];
    if (!pkt[p_sz-1])                route = D_VOID;
    else if ((addr >> level) != pos_w) route = D_UP;
    else if (addr[level-1])          route = D_RIGHT;
    else                             route = D_LEFT;
  endfunction

  // First free slot in preference order o0..o3; a free slot always exists when called.
  function automatic logic [1:0] pick(input logic [3:0] busy, input logic [1:0] o0, o1, o2, o3);
    pick = o3;
    if (!busy[o2]) pick = o2;
    if (!busy[o1]) pick = o1;
    if (!busy[o0]) pick = o0;
  endfunction

  always_comb begin
    for (int i = 0; i < 4; i++) dir[i] = route(in_q[i]);
  end

  always_comb begin
    used = '0;
    tgt  = '0;
    if (dir[S_L]  == D_LEFT)  begin tgt[S_L]  = S_L;  used[S_L]  = 1'b1; end
    if (dir[S_R]  == D_RIGHT) begin tgt[S_R]  = S_R;  used[S_R]  = 1'b1; end
    if (dir[S_U1] == D_UP)    begin tgt[S_U1] = S_U1; used[S_U1] = 1'b1; end
    if (dir[S_U2] == D_UP)    begin tgt[S_U2] = S_U2; used[S_U2] = 1'b1; end

    // Downlinks: a lost contention sends the up packet back on its own up slot.
    if (dir[S_U1] == D_LEFT && dir[S_U2] == D_LEFT && !used[S_L]) begin
      tgt[S_U1] = S_L; tgt[S_U2] = S_U1; used[S_L] = 1'b1; used[S_U1] = 1'b1;
    end else if (used[S_L]) begin
      if (dir[S_U1] == D_LEFT) begin tgt[S_U1] = S_U1; used[S_U1] = 1'b1; end
      if (dir[S_U2] == D_LEFT) begin tgt[S_U2] = S_U2; used[S_U2] = 1'b1; end
    end else if (dir[S_U1] == D_LEFT) begin tgt[S_U1] = S_L; used[S_L] = 1'b1; end
    else if (dir[S_U2] == D_LEFT)     begin tgt[S_U2] = S_L; used[S_L] = 1'b1; end

    if (dir[S_U1] == D_RIGHT && dir[S_U2] == D_RIGHT && !used[S_R]) begin
      tgt[S_U1] = S_R; tgt[S_U2] = S_U1; used[S_R] = 1'b1; used[S_U1] = 1'b1;
    end else if (used[S_R]) begin
      if (dir[S_U1] == D_RIGHT) begin tgt[S_U1] = S_U1; used[S_U1] = 1'b1; end
      if (dir[S_U2] == D_RIGHT) begin tgt[S_U2] = S_U2; used[S_U2] = 1'b1; end
    end else if (dir[S_U1] == D_RIGHT) begin tgt[S_U1] = S_R; used[S_R] = 1'b1; end
    else if (dir[S_U2] == D_RIGHT)     begin tgt[S_U2] = S_R; used[S_R] = 1'b1; end

    if (dir[S_L] == D_RIGHT) begin tgt[S_L] = pick(used, S_R, S_L, S_U1, S_U2); used[tgt[S_L]] = 1'b1; end
    if (dir[S_R] == D_LEFT)  begin tgt[S_R] = pick(used, S_L, S_R, S_U1, S_U2); used[tgt[S_R]] = 1'b1; end
    if (dir[S_L] == D_UP)    begin tgt[S_L] = pick(used, S_U1, S_U2, S_L, S_R); used[tgt[S_L]] = 1'b1; end
    if (dir[S_R] == D_UP)    begin tgt[S_R] = pick(used, S_U1, S_U2, S_R, S_L); used[tgt[S_R]] = 1'b1; end

    up_busy = used[S_U1] | used[S_U2];

    for (int i = 0; i < 4; i++) begin
      if (dir[i] == D_VOID) begin
        tgt[i] = pick(used, S_L, S_R, S_U1, S_U2);
        used[tgt[i]] = 1'b1;
      end
    end

    defl_n = '0;
    for (int i = 0; i < 4; i++) begin
      if (dir[i] != D_VOID &&
          !((dir[i] == D_LEFT && tgt[i] == S_L) || (dir[i] == D_RIGHT && tgt[i] == S_R) ||
            (dir[i] == D_UP && tgt[i][1])))
        defl_n = defl_n + 3'd1;
    end

    src = '0;
    for (int i = 0; i < 4; i++) src[tgt[i]] = 2'(i);
    for (int s = 0; s < 4; s++) begin
      slot_pkt[s] = (dir[src[s]] == D_VOID) ? '0 : in_q[src[s]];
      sel_s[s]    = src[s] + 2'd1;
    end

    cnt_sum = {1'b0, cnt_q} + {14'd0, defl_n};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_q     <= '0;
      l_q      <= '0;
      r_q      <= '0;
      ul_q     <= '0;
      ur_q     <= '0;
      sel_l_q  <= 2'b01;
      sel_r_q  <= 2'b10;
      sel_ul_q <= 2'b11;
      sel_ur_q <= 2'b00;
      toggle_q <= 1'b1;
      cnt_q    <= '0;
    end else begin
      in_q     <= {sw.ur_bus_i, sw.ul_bus_i, sw.r_bus_i, sw.l_bus_i};
      l_q      <= slot_pkt[S_L];
      r_q      <= slot_pkt[S_R];
      ul_q     <= toggle_q ? slot_pkt[S_U1] : slot_pkt[S_U2];
      ur_q     <= toggle_q ? slot_pkt[S_U2] : slot_pkt[S_U1];
      sel_l_q  <= sel_s[S_L];
      sel_r_q  <= sel_s[S_R];
      sel_ul_q <= toggle_q ? sel_s[S_U1] : sel_s[S_U2];
      sel_ur_q <= toggle_q ? sel_s[S_U2] : sel_s[S_U1];
      if (up_busy) toggle_q <= ~toggle_q;
      if (sw.defl_clr)     cnt_q <= '0;
      else if (cnt_sum[16]) cnt_q <= 16'hffff;
      else                 cnt_q <= cnt_sum[15:0];
    end
  end

  assign sw.l_bus_o  = l_q;
  assign sw.r_bus_o  = r_q;
  assign sw.ul_bus_o = ul_q;
  assign sw.ur_bus_o = ur_q;
  assign sw.sel_l    = sel_l_q;
  assign sw.sel_r    = sel_r_q;
  assign sw.sel_ul   = sel_ul_q;
  assign sw.sel_ur   = sel_ur_q;
  assign sw.defl_cnt = cnt_q;
  assign sw.toggle   = toggle_q;
endmodule

// File: tb/tb_pi_switch_ctrl.sv
// Directed-vector bench for pi_switch_ctrl (level 1, prefix 01): driver tasks push hand-computed
// expectations, a negedge monitor pops and compares them two edges later.
module tb_pi_switch_ctrl;
  localparam int P = 49;
  localparam logic [P-1:0] Z = '0;
  localparam logic [7:0] SEL_T1 = 8'b01_10_11_00;
  localparam logic [7:0] SEL_T0 = 8'b01_10_00_11;
  localparam int N_PRE = 21844;

  typedef struct packed {
    logic [31:0]  due;
    logic [P-1:0] l, r, ul, ur;
    logic [7:0]   sel;
    logic [15:0]  cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] edge_cnt = '0;
  int          n_cmp = 0;
  int          n_err = 0;
  exp_t        exp_q[$];

  pi_switch_if #(.p_sz(P)) sw();

  pi_switch_ctrl #(.p_sz(P), .addr_sz(3), .level(1), .pos(1)) dut (
    .clk(clk), .reset_n(reset_n), .sw(sw)
  );

  // Clock and edge counter
  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 32'd1;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no end of run, expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [P-1:0] pk(input logic [2:0] a, input logic [44:0] tag);
    return {1'b1, a, tag};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Driver tasks
  task automatic drive(input logic [P-1:0] l, r, ul, ur, input logic clr);
    @(negedge clk);
    sw.l_bus_i = l; sw.r_bus_i = r; sw.ul_bus_i = ul; sw.ur_bus_i = ur; sw.defl_clr = clr;
  endtask

  task automatic apply(input logic [P-1:0] l, r, ul, ur, input logic clr,
                       input logic [P-1:0] el, er, eul, eur,
                       input logic [7:0] esel, input logic [15:0] ecnt);
    exp_t e;
    drive(l, r, ul, ur, clr);
    e.due = edge_cnt + 32'd2;
    e.l = el; e.r = er; e.ul = eul; e.ur = eur; e.sel = esel; e.cnt = ecnt;
    exp_q.push_back(e);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_l_bus_o"}, 64'(sw.l_bus_o), 64'(0));
    check({tag, "_r_bus_o"}, 64'(sw.r_bus_o), 64'(0));
    check({tag, "_ul_bus_o"}, 64'(sw.ul_bus_o), 64'(0));
    check({tag, "_ur_bus_o"}, 64'(sw.ur_bus_o), 64'(0));
    check({tag, "_sel"}, 64'({sw.sel_l, sw.sel_r, sw.sel_ul, sw.sel_ur}), 64'(SEL_T1));
    check({tag, "_defl_cnt"}, 64'(sw.defl_cnt), 64'(0));
    check({tag, "_toggle"}, 64'(sw.toggle), 64'(1));
  endtask

  task automatic do_reset();
    @(negedge clk);
    exp_q.delete();
    reset_n = 1'b0;
    sw.l_bus_i = Z; sw.r_bus_i = Z; sw.ul_bus_i = Z; sw.ur_bus_i = Z; sw.defl_clr = 1'b0;
    #1 check_reset_state("reset");
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic drain();
    @(negedge clk);
    sw.l_bus_i = Z; sw.r_bus_i = Z; sw.ul_bus_i = Z; sw.ur_bus_i = Z; sw.defl_clr = 1'b0;
    for (int i = 0; i < 8 && exp_q.size() != 0; i++) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'(0));
    exp_q.delete();
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin : monitor
    exp_t e;
    if (exp_q.size() != 0 && exp_q[0].due == edge_cnt) begin
      e = exp_q.pop_front();
      check("l_bus_o", 64'(sw.l_bus_o), 64'(e.l));
      check("r_bus_o", 64'(sw.r_bus_o), 64'(e.r));
      check("ul_bus_o", 64'(sw.ul_bus_o), 64'(e.ul));
      check("ur_bus_o", 64'(sw.ur_bus_o), 64'(e.ur));
      check("sel_l_r_ul_ur", 64'({sw.sel_l, sw.sel_r, sw.sel_ul, sw.sel_ur}), 64'(e.sel));
      check("defl_cnt", 64'(sw.defl_cnt), 64'(e.cnt));
    end
  end

  initial begin : stimulus
    logic [P-1:0] a, b, c, d;
    sw.l_bus_i = Z; sw.r_bus_i = Z; sw.ul_bus_i = Z; sw.ur_bus_i = Z; sw.defl_clr = 1'b0;

    // Idle after reset: voids fill every slot straight through
    do_reset();
    repeat (5) apply(Z, Z, Z, Z, 1'b0, Z, Z, Z, Z, SEL_T1, 16'd0);
    drain();

    // L to R side link; toggle stays put
    do_reset();
    a = pk(3'd3, 45'h0_1111);
    apply(a, Z, Z, Z, 1'b0, Z, a, Z, Z, 8'b10_01_11_00, 16'd0);
    apply(Z, Z, Z, Z, 1'b0, Z, Z, Z, Z, SEL_T1, 16'd0);
    drain();

    // Both up packets want L: UL wins, UR returns on U1
    do_reset();
    a = pk(3'd2, 45'h0_2222); b = pk(3'd2, 45'h0_3333);
    apply(Z, Z, a, b, 1'b0, a, Z, b, Z, 8'b11_01_00_10, 16'd1);
    apply(Z, Z, Z, Z, 1'b0, Z, Z, Z, Z, SEL_T0, 16'd1);
    drain();

    // L to UP three times: U1 alternates between ul and ur ports
    do_reset();
    a = pk(3'd0, 45'h0_4441); b = pk(3'd0, 45'h0_4442); c = pk(3'd0, 45'h0_4443);
    apply(a, Z, Z, Z, 1'b0, Z, Z, a, Z, 8'b10_11_01_00, 16'd0);
    apply(b, Z, Z, Z, 1'b0, Z, Z, Z, b, 8'b10_11_00_01, 16'd0);
    apply(c, Z, Z, Z, 1'b0, Z, Z, c, Z, 8'b10_11_01_00, 16'd0);
    apply(Z, Z, Z, Z, 1'b0, Z, Z, Z, Z, SEL_T0, 16'd0);
    drain();

    // Mixed full loads, deflections and clear beating a same-edge add
    do_reset();
    a = pk(3'd3, 45'h0_5001); b = pk(3'd2, 45'h0_5002); c = pk(3'd0, 45'h0_5003); d = pk(3'd5, 45'h0_5004);
    apply(a, b, c, d, 1'b0, b, a, c, d, 8'b10_01_11_00, 16'd0);
    a = pk(3'd2, 45'h0_6001); b = pk(3'd0, 45'h0_6002); c = pk(3'd2, 45'h0_6003); d = pk(3'd2, 45'h0_6004);
    apply(a, b, c, d, 1'b0, a, b, d, c, 8'b01_10_00_11, 16'd3);
    a = pk(3'd0, 45'h0_7001); b = pk(3'd1, 45'h0_7002); c = pk(3'd3, 45'h0_7003);
    apply(a, b, c, Z, 1'b0, Z, c, a, b, 8'b00_11_01_10, 16'd3);
    a = pk(3'd3, 45'h0_8001); b = pk(3'd3, 45'h0_8002); c = pk(3'd3, 45'h0_8003);
    apply(a, b, c, Z, 1'b0, a, b, Z, c, 8'b01_10_00_11, 16'd5);
    a = pk(3'd2, 45'h0_9001); b = pk(3'd0, 45'h0_9002); c = pk(3'd2, 45'h0_9003); d = pk(3'd2, 45'h0_9004);
    apply(a, b, c, d, 1'b0, a, b, c, d, SEL_T1, 16'd0);
    apply(Z, Z, Z, Z, 1'b1, Z, Z, Z, Z, SEL_T0, 16'd0);
    apply(Z, Z, Z, Z, 1'b0, Z, Z, Z, Z, SEL_T0, 16'd0);
    drain();

    // Reset mid-flight: one packet on the outputs, one in stage 1
    do_reset();
    a = pk(3'd3, 45'h0_a001); b = pk(3'd3, 45'h0_a002);
    drive(a, Z, Z, Z, 1'b0);
    drive(b, Z, Z, Z, 1'b0);
    @(negedge clk);
    check("midflight_r_bus_o_before_reset", 64'(sw.r_bus_o), 64'(a));
    reset_n = 1'b0;
    sw.l_bus_i = Z;
    #1 check_reset_state("midflight");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) apply(Z, Z, Z, Z, 1'b0, Z, Z, Z, Z, SEL_T1, 16'd0);
    drain();

    // Saturation: three deflections per cycle reach FFFF exactly, then clamp, then clear
    do_reset();
    a = pk(3'd2, 45'h0_b001); b = pk(3'd0, 45'h0_b002); c = pk(3'd2, 45'h0_b003); d = pk(3'd2, 45'h0_b004);
    for (int i = 0; i < N_PRE; i++) drive(a, b, c, d, 1'b0);
    apply(a, b, c, d, 1'b0, a, b, c, d, SEL_T1, 16'hffff);
    apply(a, b, c, d, 1'b0, a, b, d, c, 8'b01_10_00_11, 16'hffff);
    apply(Z, Z, Z, Z, 1'b0, Z, Z, Z, Z, SEL_T1, 16'd0);
    apply(Z, Z, Z, Z, 1'b1, Z, Z, Z, Z, SEL_T1, 16'd0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
